// File: rtl/instruction_fetch.sv
// Multi-cycle fetch stage: reads one word at PC into IR, then PC += 2.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int               WORD           = 16,
    parameter logic [WORD-1:0]  RESET_PC       = '0,
    parameter int               TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic            pc_load,
    input  logic [WORD-1:0] pc_load_val,
    output logic [WORD-1:0] mem_addr,
    output logic            mem_rd,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata,
    output logic [WORD-1:0] inst,
    output logic            inst_valid,
    output logic [WORD-1:0] pc,
    output logic            busy,
    output logic            fetch_fault
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    if (RESET_PC[0] != 1'b0) begin : g_bad_pc
        $error("RESET_PC must be halfword aligned");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e          state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = 16;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        fault_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef FETCH_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (pc_load) begin
                    pc_d = {pc_load_val[WORD-1:1], 1'b0};
                end
                if (fetch_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    inst_d  = mem_rdata;
                    pc_d    = pc_q + WORD'(2);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                // An ack in the expiry cycle takes priority over the fault.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign mem_rd     = (state_q == FETCH);
    assign busy       = (state_q == FETCH);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (TIMEOUT_CYCLES=4).
// Timeout vectors are selected by FETCH_TIMEOUT_EN.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int rd_cycles;

    instruction_fetch #(
        .WORD(16),
        .RESET_PC(16'h0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_req(fetch_req),
        .pc_load(pc_load),
        .pc_load_val(pc_load_val),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .inst(inst),
        .inst_valid(inst_valid),
        .pc(pc),
        .busy(busy),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0;
        pc_load = 1'b0;
        pc_load_val = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_pc", pc, 16'h0000);
        check("rst_inst", inst, 16'h0000);
        check("rst_valid", {15'b0, inst_valid}, 16'h0);
        check("rst_rd", {15'b0, mem_rd}, 16'h0);
        check("rst_busy", {15'b0, busy}, 16'h0);
        check("rst_fault", {15'b0, fetch_fault}, 16'h0);

        // zero-wait fetch
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h4C8A;
        tick();
        fetch_req = 1'b0;
        check("zw_rd", {15'b0, mem_rd}, 16'h1);
        check("zw_busy", {15'b0, busy}, 16'h1);
        check("zw_addr", mem_addr, 16'h0000);
        check("zw_valid0", {15'b0, inst_valid}, 16'h0);
        tick();
        mem_ack = 1'b0;
        check("zw_inst", inst, 16'h4C8A);
        check("zw_pc", pc, 16'h0002);
        check("zw_valid", {15'b0, inst_valid}, 16'h1);
        check("zw_rd_off", {15'b0, mem_rd}, 16'h0);
        check("zw_busy_off", {15'b0, busy}, 16'h0);
        tick();
        check("zw_pulse", {15'b0, inst_valid}, 16'h0);
        check("zw_hold", inst, 16'h4C8A);

        // three wait states
        mem_rdata = 16'h6123;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd) rd_cycles++;
            check("ws_addr", mem_addr, 16'h0002);
            check("ws_inst_old", inst, 16'h4C8A);
            tick();
        end
        if (mem_rd) rd_cycles++;
        check("ws_addr4", mem_addr, 16'h0002);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ws_rd_cycles", 16'(rd_cycles), 16'd4);
        check("ws_inst", inst, 16'h6123);
        check("ws_pc", pc, 16'h0004);
        check("ws_valid", {15'b0, inst_valid}, 16'h1);

        // pc_load together with fetch_req
        pc_load = 1'b1;
        pc_load_val = 16'h1235;
        fetch_req = 1'b1;
        mem_rdata = 16'hA5A5;
        tick();
        pc_load = 1'b0;
        fetch_req = 1'b0;
        check("ld_addr", mem_addr, 16'h1234);
        check("ld_busy", {15'b0, busy}, 16'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ld_pc", pc, 16'h1236);
        check("ld_inst", inst, 16'hA5A5);

        // load odd address, spurious ack while idle
        pc_load = 1'b1;
        pc_load_val = 16'hFFFF;
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        pc_load = 1'b0;
        mem_ack = 1'b0;
        check("wr_pc_ld", pc, 16'hFFFE);
        check("idle_ack_inst", inst, 16'hA5A5);
        check("idle_ack_valid", {15'b0, inst_valid}, 16'h0);
        check("idle_ack_rd", {15'b0, mem_rd}, 16'h0);
        fetch_req = 1'b1;
        tick();
        // pc_load during FETCH must be ignored
        pc_load = 1'b1;
        pc_load_val = 16'h0800;
        tick();
        pc_load = 1'b0;
        fetch_req = 1'b0;
        check("fetch_ld_ign", pc, 16'hFFFE);
        check("fetch_ld_busy", {15'b0, busy}, 16'h1);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("wrap_pc", pc, 16'h0000);
        check("wrap_inst", inst, 16'hBEEF);

        // back-to-back fetches
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h1357;
        tick();
        tick();
        check("b2b_v1", {15'b0, inst_valid}, 16'h1);
        check("b2b_pc1", pc, 16'h0002);
        mem_rdata = 16'h2468;
        tick();
        check("b2b_restart", {15'b0, busy}, 16'h1);
        check("b2b_addr", mem_addr, 16'h0002);
        check("b2b_v_low", {15'b0, inst_valid}, 16'h0);
        fetch_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("b2b_v2", {15'b0, inst_valid}, 16'h1);
        check("b2b_inst2", inst, 16'h2468);
        check("b2b_pc2", pc, 16'h0004);

        // reset in second FETCH cycle with ack high
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        check("rmf_busy", {15'b0, busy}, 16'h1);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        check("rmf_inst", inst, 16'h0000);
        check("rmf_pc", pc, 16'h0000);
        check("rmf_valid", {15'b0, inst_valid}, 16'h0);
        check("rmf_rd", {15'b0, mem_rd}, 16'h0);

`ifdef FETCH_TIMEOUT_EN
        // watchdog expiry after 4 FETCH cycles
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_busy", {15'b0, busy}, 16'h1);
            check("to_nofault", {15'b0, fetch_fault}, 16'h0);
        end
        tick();
        check("to_fault", {15'b0, fetch_fault}, 16'h1);
        check("to_rd", {15'b0, mem_rd}, 16'h0);
        check("to_pc", pc, 16'h0000);
        check("to_inst", inst, 16'h0000);
        check("to_valid", {15'b0, inst_valid}, 16'h0);
        tick();
        check("to_pulse", {15'b0, fetch_fault}, 16'h0);

        // ack in the expiry cycle wins
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 16'h7E7E;
        tick();
        mem_ack = 1'b0;
        check("tw_fault", {15'b0, fetch_fault}, 16'h0);
        check("tw_valid", {15'b0, inst_valid}, 16'h1);
        check("tw_inst", inst, 16'h7E7E);
        check("tw_pc", pc, 16'h0002);
`else
        // without the watchdog FETCH waits indefinitely
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("nt_busy", {15'b0, busy}, 16'h1);
        check("nt_rd", {15'b0, mem_rd}, 16'h1);
        check("nt_fault", {15'b0, fetch_fault}, 16'h0);
        mem_ack = 1'b1;
        mem_rdata = 16'h7E7E;
        tick();
        mem_ack = 1'b0;
        check("nt_inst", inst, 16'h7E7E);
        check("nt_pc", pc, 16'h0002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Multi-cycle fetch stage directly upstream of `instruction_decoder`. On request from the control unit it reads one 16-bit instruction word from memory at the current PC and latches it into the instruction register (IR). The IR drives the decoder's `inst` input. The block then advances the PC by 2 and accepts PC loads for branch, link and reset redirection.

## Interface
- `WORD`, 16: instruction and address width.
- `RESET_PC`, 16'h0000: PC value after reset; bit 0 must be 0.
- `TIMEOUT_CYCLES`, 16: fetch watchdog limit. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  control unit requests one instruction fetch.
- `pc_load`  in  1  load PC from `pc_load_val`.
- `pc_load_val`  in  WORD  new PC (branch target); bit 0 forced to 0.
- `mem_addr`  out  WORD  fetch address; always equals `pc`.
- `mem_rd`  out  1  memory read strobe, high for the whole FETCH state.
- `mem_ack`  in  1  memory has `mem_rdata` valid this cycle.
- `mem_rdata`  in  WORD  instruction word from memory.
- `inst`  out  WORD  IR contents, to the decoder's `inst`.
- `inst_valid`  out  1  one-cycle pulse: IR updated on the previous edge.
- `pc`  out  WORD  current PC (address of next fetch).
- `busy`  out  1  high while in FETCH.
- `fetch_fault`  out  1  one-cycle pulse on watchdog expiry. Constant 0 without the macro.

## Operation
- Two-state FSM: IDLE and FETCH. All outputs are registered or decoded from the state only.
- Reset values: state=IDLE, `pc`=RESET_PC, `inst`=16'h0000, `inst_valid`=0, `mem_rd`=0, `busy`=0, `fetch_fault`=0, watchdog counter=0.
- IDLE, `pc_load`=1: `pc` <= {`pc_load_val`[15:1],1'b0}.
- IDLE, `fetch_req`=1: go to FETCH.
- IDLE, both `pc_load` and `fetch_req`: both are taken. The PC loads and FETCH is entered on the same edge, so the fetch uses the new PC.
- FETCH: `mem_rd`=1 and `busy`=1.
  - On a cycle where `mem_ack`=1: `inst` <= `mem_rdata`, `pc` <= `pc`+2 modulo 2^WORD (0xFFFE wraps to 0x0000), `inst_valid` <= 1, go to IDLE.
- FETCH ignores `pc_load` and `fetch_req`; the PC is not modified except on ack.
- `mem_ack` outside FETCH is ignored; `inst` is unchanged.
- `inst` holds its value until the next acked fetch. The decoder may sample it for any number of cycles.
- `rst` in any state aborts an in-flight fetch. The next state is the reset state and any `mem_ack` in that cycle is discarded.

## Timing
- `fetch_req` sampled high at edge E0 gives `mem_rd`=1 from cycle E0+ onward.
- Zero-wait memory: `mem_ack` is high in the first FETCH cycle and sampled at E1. At E1, `inst` and `pc` update. In the cycle after E1, `inst_valid`=1, `mem_rd`=0 and `busy`=0.
- Minimum fetch is 2 edges from request to valid IR. Each wait state adds 1 cycle.
- Back-to-back: `fetch_req` held high through the `inst_valid` cycle restarts FETCH on the next edge. Throughput is one instruction per 2 cycles at zero wait.
- `mem_addr` is stable for the whole FETCH state.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without ack.
  - If it reaches TIMEOUT_CYCLES with no ack, the FSM returns to IDLE and `mem_rd` drops. `fetch_fault` pulses for 1 cycle. `inst` and `pc` are unchanged and `inst_valid` stays 0.
  - An ack arriving in the expiry cycle wins; no fault is raised.
- Not defined: no counter. FETCH waits indefinitely for `mem_ack` and `fetch_fault` is tied 0.

## Test plan
- Reset then zero-wait fetch: RESET_PC=0, `mem_rdata`=16'h4C8A acked in the first FETCH cycle → `inst`=16'h4C8A, `pc`=0x0002, `inst_valid` pulses once, 2 cycles after the request.
- Wait states: ack after 3 wait cycles with `mem_rdata`=16'h6123 → `mem_rd` high for 4 cycles with `mem_addr` constant, then `inst`=16'h6123.
- Simultaneous `pc_load`=1 (`pc_load_val`=0x1235) and `fetch_req` in IDLE → `mem_addr`=0x1234 during FETCH; after ack `pc`=0x1236.
- Wrap and ignore: `pc`=0xFFFE, fetch acked → `pc`=0x0000. A `pc_load` and a spurious `mem_ack` during FETCH or IDLE respectively are ignored.
- Reset mid-fetch: `rst` in the second FETCH cycle with `mem_ack` high → `inst`=0, `pc`=RESET_PC, `inst_valid`=0.
- `FETCH_TIMEOUT_EN`, TIMEOUT_CYCLES=4, no ack → `fetch_fault` pulses once after 4 FETCH cycles. `mem_rd` drops, and `pc` and `inst` are unchanged.
